// File: rtl/wallace_mac_acc.sv
// Multiply-accumulate back end: sums N_TERMS unsigned 8-bit products per frame
// and hands the finished sum downstream over a valid/ready port.
module wallace_mac_acc #(
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 4,
  localparam int CNT_W  = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic [CNT_W-1:0] term_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W:0]   sum_s;

  // Next-state logic; clear beats both the accept and the output handshake.
  always_comb begin
    sum_s   = {1'b0, acc_q} + {{(ACC_W + 1 - 8){1'b0}}, prod};
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ST_ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            acc_d = sum_s[ACC_W-1:0];
            ovf_d = ovf_q | sum_s[ACC_W];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ACC;
            end
          end else begin
            state_d = ST_ACC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_ACC;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign term_cnt  = cnt_q;

endmodule
